// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback source handshake (valid/rd/data with ready back)
interface rf_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              valid;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] data;
  logic              ready;
  modport master(output valid, rd, data, input ready);
  modport slave(input valid, rd, data, output ready);
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: LSU-priority register-file write port arbiter with ALU starvation guard
module rf_wb_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  rf_wb_arbiter_if.slave     alu,
  rf_wb_arbiter_if.slave     lsu,
  output logic               wen_o,
  output logic [ADDR_W-1:0]  rd_o,
  output logic [DATA_W-1:0]  rd_data_o,
  output logic               starve_o
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  typedef enum logic {NORMAL, FORCE_ALU} state_e;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              alu_rdy, lsu_rdy;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end
  always_comb begin
    cnt_d   = (alu.valid && !alu_rdy) ? cnt_q + 1'b1 : '0;
    state_d = (state_q == NORMAL && cnt_d == CW'(STARVE_MAX)) ? FORCE_ALU : NORMAL;
  end
  // FORCE_ALU lasts exactly one cycle; the ALU request is still held there
  always_comb begin
    alu_rdy  = !rst && alu.valid && (state_q == FORCE_ALU || !lsu.valid);
    lsu_rdy  = !rst && lsu.valid && state_q == NORMAL;
    starve_o = state_q == FORCE_ALU;
    rd_d     = lsu_rdy ? lsu.rd : alu_rdy ? alu.rd : rd_q;
    data_d   = lsu_rdy ? lsu.data : alu_rdy ? alu.data : data_q;
    wen_d    = (lsu_rdy || alu_rdy) && rd_d != '0;
  end
  assign alu.ready = alu_rdy;
  assign lsu.ready = lsu_rdy;
  assign wen_o     = wen_q;
  assign rd_o      = rd_q;
  assign rd_data_o = data_q;
endmodule
